// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: opcode/funct fields,
// mult/div op classes and the ALU operation set.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1a;
    localparam logic [5:0] FN_DIVU    = 6'h1b;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2a;
    localparam logic [5:0] FN_SLTU    = 6'h2b;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU
    } md_op_e;

    typedef enum logic [3:0] {
        ALU_ZERO,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLTU,
        ALU_LUI,
        ALU_PC8,
        ALU_HI,
        ALU_LO
    } alu_op_e;

    function automatic logic is_mult(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle mult/div unit owning HI/LO.
// FAST_MULT_EN: mult/multu commit at the start edge, never go busy.
import mips_pkg::*;

module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  md_op_e      md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {S_IDLE, S_BUSY} state_e;

`ifdef FAST_MULT_EN
    localparam logic [CNT_W-1:0] MULT_LAT = '0;
`else
    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES - 1);
`endif
    localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_op_e             op_q, op_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;

    md_op_e             ex_op;
    logic [31:0]        ex_a, ex_b;
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        res_hi, res_lo;
    logic               res_we, commit;

    // A one-cycle op commits from the live inputs, otherwise from the latch.
    assign ex_op = (state_q == S_IDLE) ? md_op : op_q;
    assign ex_a  = (state_q == S_IDLE) ? a : a_q;
    assign ex_b  = (state_q == S_IDLE) ? b : b_q;

    assign prod_s = $signed({{32{ex_a[31]}}, ex_a})
                  * $signed({{32{ex_b[31]}}, ex_b});
    assign prod_u = {32'b0, ex_a} * {32'b0, ex_b};

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_we = 1'b1;
        unique case (ex_op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                res_we = (ex_b != '0);
                if (res_we) begin
                    res_lo = $signed(ex_a) / $signed(ex_b);
                    res_hi = $signed(ex_a) % $signed(ex_b);
                end
            end
            MD_DIVU: begin
                res_we = (ex_b != '0);
                if (res_we) begin
                    res_lo = ex_a / ex_b;
                    res_hi = ex_a % ex_b;
                end
            end
            default: res_we = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = md_op;
                    a_d   = a;
                    b_d   = b;
                    cnt_d = is_mult(md_op) ? MULT_LAT : DIV_LAT;
                    if (cnt_d == '0) commit = 1'b1;
                    else             state_d = S_BUSY;
                end else begin
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (commit && res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/execute_stage.sv
// E stage of the 5-stage MIPS pipeline: ALU, mult/div unit and E/M register.
// FAST_MULT_EN selects single-cycle mult/multu.
import mips_pkg::*;

module execute_stage #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_PC,
    input  logic [31:0] E_Ins,
    input  logic [31:0] E_EXT_out,
    input  logic [31:0] E_rs_fw,
    input  logic [31:0] E_rt_fw,
    output logic [31:0] E_ALU_out,
    output logic        E_Start,
    output logic        E_Busy,
    output logic [31:0] M_PC,
    output logic [31:0] M_Ins,
    output logic [31:0] M_ALU_out,
    output logic [31:0] M_rt_data
);

    logic [5:0]  opcode, funct;
    alu_op_e     alu_op;
    logic        use_imm, md_valid, is_mthi, is_mtlo;
    md_op_e      md_op;
    logic [31:0] opb, hi, lo, alu_res;
    logic [31:0] m_pc_q, m_ins_q, m_alu_q, m_rt_q;
    logic [9:0]  unused_ins;

    assign opcode     = E_Ins[31:26];
    assign funct      = E_Ins[5:0];
    assign unused_ins = E_Ins[25:16];

    always_comb begin
        alu_op   = ALU_ZERO;
        use_imm  = 1'b0;
        md_valid = 1'b0;
        md_op    = MD_MULT;
        is_mthi  = 1'b0;
        is_mtlo  = 1'b0;
        unique case (opcode)
            OP_SPECIAL: begin
                unique case (funct)
                    FN_ADDU:  alu_op = ALU_ADD;
                    FN_SUBU:  alu_op = ALU_SUB;
                    FN_AND:   alu_op = ALU_AND;
                    FN_OR:    alu_op = ALU_OR;
                    FN_SLT:   alu_op = ALU_SLT;
                    FN_SLTU:  alu_op = ALU_SLTU;
                    FN_JALR:  alu_op = ALU_PC8;
                    FN_MFHI:  alu_op = ALU_HI;
                    FN_MFLO:  alu_op = ALU_LO;
                    FN_MTHI:  is_mthi = 1'b1;
                    FN_MTLO:  is_mtlo = 1'b1;
                    FN_MULT:  begin md_valid = 1'b1; md_op = MD_MULT;  end
                    FN_MULTU: begin md_valid = 1'b1; md_op = MD_MULTU; end
                    FN_DIV:   begin md_valid = 1'b1; md_op = MD_DIV;   end
                    FN_DIVU:  begin md_valid = 1'b1; md_op = MD_DIVU;  end
                    default:  alu_op = ALU_ZERO;
                endcase
            end
            OP_ORI:  begin alu_op = ALU_OR;  use_imm = 1'b1; end
            OP_ANDI: begin alu_op = ALU_AND; use_imm = 1'b1; end
            OP_LW,
            OP_SW:   begin alu_op = ALU_ADD; use_imm = 1'b1; end
            OP_LUI:  alu_op = ALU_LUI;
            OP_JAL:  alu_op = ALU_PC8;
            default: alu_op = ALU_ZERO;
        endcase
    end

    assign opb = use_imm ? E_EXT_out : E_rt_fw;

    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            ALU_ADD:  alu_res = E_rs_fw + opb;
            ALU_SUB:  alu_res = E_rs_fw - opb;
            ALU_AND:  alu_res = E_rs_fw & opb;
            ALU_OR:   alu_res = E_rs_fw | opb;
            ALU_SLT:  alu_res = {31'b0, $signed(E_rs_fw) < $signed(opb)};
            ALU_SLTU: alu_res = {31'b0, E_rs_fw < opb};
            ALU_LUI:  alu_res = {E_Ins[15:0], 16'b0};
            ALU_PC8:  alu_res = E_PC + 32'd8;
            ALU_HI:   alu_res = hi;
            ALU_LO:   alu_res = lo;
            default:  alu_res = '0;
        endcase
    end

    assign E_ALU_out = alu_res;
    assign E_Start   = md_valid & ~E_Busy;

    muldiv_unit #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (E_Start),
        .md_op (md_op),
        .a     (E_rs_fw),
        .b     (E_rt_fw),
        .wr_hi (is_mthi & ~E_Busy),
        .wr_lo (is_mtlo & ~E_Busy),
        .wdata (E_rs_fw),
        .busy  (E_Busy),
        .hi    (hi),
        .lo    (lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc_q  <= '0;
            m_ins_q <= '0;
            m_alu_q <= '0;
            m_rt_q  <= '0;
        end else begin
            m_pc_q  <= E_PC;
            m_ins_q <= E_Ins;
            m_alu_q <= E_ALU_out;
            m_rt_q  <= E_rt_fw;
        end
    end

    assign M_PC      = m_pc_q;
    assign M_Ins     = m_ins_q;
    assign M_ALU_out = m_alu_q;
    assign M_rt_data = m_rt_q;

endmodule
